// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle unsigned multiply / divide unit with its own sequencing FSM.
// It serves the register-pair writeback instructions: the operands are latched
// on accept, the unit iterates one bit per cycle (shift-add multiply or
// restoring divide), holds the pipeline through `stall`, and then presents a
// double-width result as hi/lo halves with a one-cycle `done`/`wbPair` pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE
//   multiDiv   in   2'b01 = unsigned multiply, 2'b10 = unsigned divide
//   opA        in   multiplicand / dividend
//   opB        in   multiplier / divisor
//   busy       out  high while iterating (MUL or DIV)
//   stall      out  busy, or an acceptable request sitting in IDLE
//   done       out  one-cycle completion pulse
//   wbPair     out  write enable for both destination registers (== done)
//   resultHi   out  product upper half / remainder
//   resultLo   out  product lower half / quotient
//   divByZero  out  last completed divide had a zero divisor
//
// Optional feature
//   MULDIV_EARLY_OUT_EN : multiply finishes as soon as the remaining
//                         multiplier bits are all zero (minimum one
//                         iteration). Divide latency is unchanged.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       multiDiv,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             wbPair,
   output logic [WIDTH-1:0] resultHi,
   output logic [WIDTH-1:0] resultLo,
   output logic             divByZero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   // hi_q is the multiply accumulator / divide remainder; lo_q is the
   // multiplier (shifting out, product bits shifting in) / dividend-quotient.
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   // Multiplicand for MUL, divisor for DIV.
   logic [WIDTH-1:0] opnd_q;
   logic             dz_q;

   logic             valid_op;
   logic             accept;
   logic [CW-1:0]    cnt_dec;

   // ---------------------------------------------------------------- control
   assign valid_op = (multiDiv == OP_MUL) || (multiDiv == OP_DIV);
   assign accept   = (state == S_IDLE) && start && valid_op;
   assign busy     = (state == S_MUL) || (state == S_DIV);
   assign stall    = busy || accept;
   assign done     = (state == S_DONE);
   assign wbPair   = done;
   assign cnt_dec  = cnt - 1'b1;

   // --------------------------------------------------------- multiply step
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi;
   logic [WIDTH-1:0]   mul_lo;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_last;

   // The carry out of the add lands in the MSB of the accumulator after the
   // right shift, so no product bit is lost.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
   // After this edge the unconsumed multiplier bits are the low cnt_dec bits
   // of mul_lo. Once they are zero the remaining iterations would only shift,
   // so the alignment shift is applied in one go.
   logic [WIDTH-1:0] rem_mask;
   assign rem_mask = ~({WIDTH{1'b1}} << cnt_dec);
   assign mul_last = (cnt_dec == '0) || ((mul_lo & rem_mask) == '0);
   assign mul_prod = {mul_hi, mul_lo} >> cnt_dec;
`else
   assign mul_last = (cnt_dec == '0);
   assign mul_prod = {mul_hi, mul_lo};
`endif

   // ----------------------------------------------------------- divide step
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_quo;

   // The remainder is always below the divisor, so the shifted value fits
   // in WIDTH+1 bits and bit WIDTH of the difference is a clean sign bit.
   assign div_sh   = {hi_q, lo_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign div_quo  = {lo_q[WIDTH-2:0], div_ge};

   // -------------------------------------------------------------- sequencer
   // NOTE: every register here, datapath included, is cleared by reset so the
   // results read back as zero immediately after an abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         dz_q      <= 1'b0;
         resultHi  <= '0;
         resultLo  <= '0;
         divByZero <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand
         // side sees the pre-edge value of the state.
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt  <= CW'(WIDTH);
                  hi_q <= '0;
                  dz_q <= (multiDiv == OP_DIV) && (opB == '0);
                  if (multiDiv == OP_MUL) begin
                     state  <= S_MUL;
                     lo_q   <= opB;
                     opnd_q <= opA;
                  end else begin
                     state  <= S_DIV;
                     lo_q   <= opA;
                     opnd_q <= opB;
                  end
               end
            end

            S_MUL: begin
               hi_q <= mul_hi;
               lo_q <= mul_lo;
               if (mul_last) begin
                  state     <= S_DONE;
                  cnt       <= '0;
                  resultHi  <= mul_prod[2*WIDTH-1:WIDTH];
                  resultLo  <= mul_prod[WIDTH-1:0];
                  divByZero <= 1'b0;
               end else begin
                  cnt <= cnt_dec;
               end
            end

            S_DIV: begin
               if (dz_q) begin
                  // Zero divisor: a single cycle in DIV, then the
                  // conventional all-ones quotient and dividend remainder.
                  state     <= S_DONE;
                  cnt       <= '0;
                  resultHi  <= lo_q;
                  resultLo  <= '1;
                  divByZero <= 1'b1;
               end else begin
                  hi_q <= div_rem;
                  lo_q <= div_quo;
                  cnt  <= cnt_dec;
                  if (cnt_dec == '0) begin
                     state     <= S_DONE;
                     resultHi  <= div_rem;
                     resultLo  <= div_quo;
                     divByZero <= 1'b0;
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit sequenced by its own FSM, serving type-A instructions whose `multiDiv` field is non-zero (the register-pair write case, `regWrite = 2'b11`). It accepts two `WIDTH`-bit operands, runs an iterative shift-add multiply or restoring divide one bit per cycle, and holds the pipeline via `stall` until completion. At completion it presents a double-width result as hi/lo halves for the register-pair writeback.

## Interface
- `WIDTH`, default 16: operand width; results are two `WIDTH`-bit halves.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `multiDiv`  in  2  op select: 01 = unsigned multiply, 10 = unsigned divide; 00 and 11 are not accepted.
- `opA`  in  WIDTH  multiplicand / dividend; latched on accept.
- `opB`  in  WIDTH  multiplier / divisor; latched on accept.
- `busy`  out  1  high in MUL or DIV.
- `stall`  out  1  combinational: `busy | (state==IDLE & start & multiDiv∈{01,10})`.
- `done`  out  1  single-cycle pulse in DONE.
- `wbPair`  out  1  equals `done`; write enable for both destination registers.
- `resultHi`  out  WIDTH  product upper half / remainder.
- `resultLo`  out  WIDTH  product lower half / quotient.
- `divByZero`  out  1  set in DONE of a divide with `opB==0`; held with results.

## Operation
- States: IDLE, MUL, DIV, DONE; 2-bit state register, plus a `$clog2(WIDTH+1)`-bit iteration counter.
- IDLE: `start` with `multiDiv==01` goes to MUL; with `multiDiv==10` goes to DIV. Operands are latched, the counter is set to WIDTH, and the accumulator is cleared. Any other `multiDiv` is ignored and the FSM stays in IDLE.
- MUL, each cycle:
  - If multiplier LSB is 1, add multiplicand to the accumulator upper half (WIDTH+1-bit sum, carry kept).
  - Shift {carry, acc, multiplier} right by 1 and decrement the counter.
  - Counter reaching 0 goes to DONE.
- DIV, each cycle:
  - Shift {rem, quo} left by 1 and compute trial `rem − divisor` at WIDTH+1 bits.
  - Non-negative: rem = difference and quotient LSB = 1. Negative: rem unchanged and LSB = 0.
  - Decrement the counter; 0 goes to DONE.
- Divide by zero: detected on accept. DIV spends exactly one cycle, then DONE with `resultLo=all-ones`, `resultHi=opA`, `divByZero=1`.
- DONE: `done=wbPair=1` for one cycle, then IDLE. `start` is ignored in DONE.
- `resultHi`, `resultLo` and `divByZero` update only on entry to DONE. They hold until the next DONE and do not change during the next operation.
- `start` while busy is ignored and operands are not re-latched.

## Timing
- Reset (async assert): state IDLE, counter 0, `busy=stall=done=wbPair=divByZero=0`, `resultHi=resultLo=0`.
- Reset mid-operation aborts immediately with no `done`. The first edge after deassert behaves as IDLE.
- Accept edge E0 is followed by WIDTH iteration edges E1..E_WIDTH. `done` is high between E_WIDTH and E_WIDTH+1, so done rises WIDTH+1 cycles after the cycle in which `start` was sampled.
- Divide-by-zero: `done` high between E1 and E2.
- `stall` is high from the `start` cycle through the last MUL/DIV cycle. It is low in DONE, so the stalled instruction advances and writes back on `wbPair`.
- Back-to-back operation: a new `start` is accepted no earlier than the cycle after DONE.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - MUL goes to DONE after the first iteration edge at which the remaining shifted multiplier is zero. The final product is aligned by shifting {acc, multiplier} right by the remaining count in that same edge.
  - Minimum 1 iteration; a multiplier of 0 gives `done` after E1.
  - DIV is unaffected.
- Undefined: MUL always runs exactly WIDTH iterations, with fixed latency.

## Test plan
- MUL 0x1234×0x0010 (WIDTH=16, macro off) -> `resultHi=0x0001`, `resultLo=0x2340`. `busy` high for 16 cycles, `done`/`wbPair` one cycle, then IDLE.
- MUL 0xFFFF×0xFFFF -> `resultHi=0xFFFE`, `resultLo=0x0001`, carry handled correctly.
- DIV 0x0064÷0x0007 -> `resultLo=0x000E`, `resultHi=0x0002`, `divByZero=0`, `done` 17 cycles after the `start` cycle.
- DIV 0x1234÷0x0000 -> `resultLo=0xFFFF`, `resultHi=0x1234`, `divByZero=1`, `done` 2 cycles after the `start` cycle.
- Mid-MUL: pulse `start` with new operands -> ignored, result unchanged. Assert `rst_n=0` at iteration 8 -> all outputs 0 at once, no `done`. A subsequent DIV 0x0064÷0x0007 completes correctly. `start` with `multiDiv=11` -> no accept, `stall=0`.
- `MULDIV_EARLY_OUT_EN` defined: MUL 0x1234×0x0003 -> `done` after E2 with `resultHi=0x0000`, `resultLo=0x369C`. MUL ×0x0000 -> `done` after E1, results 0. Macro undefined: same multiply takes 16 iterations, same result.
